// File: rtl/kyber_pkg.sv
// Shared Kyber constants and loader state type.
package kyber_pkg;

  localparam int KYBER_Q        = 3329;
  localparam int COEF_W         = 12;
  localparam int COEFS_PER_WORD = 8;
  localparam int WORDS_PER_POLY = 32;
  localparam int WORD_W         = COEF_W * COEFS_PER_WORD;
  localparam int LANE_W         = $clog2(COEFS_PER_WORD);
  localparam int WIDX_W         = $clog2(WORDS_PER_POLY);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } load_state_e;

endpackage

// File: rtl/coef_cond_sub.sv
// Combinational single conditional subtraction of q.
// A 12-bit input is always < 2q, so one subtraction fully reduces it.
module coef_cond_sub
  import kyber_pkg::*;
(
  input  logic [COEF_W-1:0] x_i,
  output logic [COEF_W-1:0] y_o,
  output logic              ge_q_o
);

  assign ge_q_o = (x_i >= COEF_W'(KYBER_Q));
  assign y_o    = ge_q_o ? (x_i - COEF_W'(KYBER_Q)) : x_i;

endmodule

// File: rtl/poly_loader.sv
// Polynomial loader: packs sampled coefficients 8 per word and writes
// 32 words starting at base_addr (address wraps modulo 256).
// Optional build macro POLY_LOADER_REJECT_EN: coefficients >= q are
// consumed and dropped (rejection sampling) instead of being reduced.
module poly_loader
  import kyber_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          base_addr,
  input  logic [COEF_W-1:0]   in_coef,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WORD_W-1:0]   w_data,
  output logic [7:0]          w_addr,
  output logic                w_en,
  output logic                busy,
  output logic                done
);

  load_state_e         state_q;
  logic [7:0]          base_q;
  logic [WIDX_W-1:0]   word_idx_q;
  logic [LANE_W-1:0]   lane_q;
  logic [WORD_W-1:0]   buf_q;
  logic [WORD_W-1:0]   w_data_q;
  logic [7:0]          w_addr_q;
  logic                w_en_q;
  logic                done_q;

  logic [COEF_W-1:0]   red;
  logic                ge_q;
  logic [COEF_W-1:0]   coef_d;
  logic                hs;
  logic                keep;
  logic [WORD_W-1:0]   word_d;

  coef_cond_sub u_cond_sub (
    .x_i    (in_coef),
    .y_o    (red),
    .ge_q_o (ge_q)
  );

  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q != ST_IDLE);
  assign w_data   = w_data_q;
  assign w_addr   = w_addr_q;
  assign w_en     = w_en_q;
  assign done     = done_q;

  assign hs     = in_valid && in_ready;
  // Values below q pass through unchanged; ge_q picks the reduced form.
  assign coef_d = ge_q ? red : in_coef;

`ifdef POLY_LOADER_REJECT_EN
  assign keep = hs && !ge_q;
`else
  assign keep = hs;
`endif

  // Insert the incoming coefficient into the current lane of the packing buffer.
  always_comb begin
    word_d = buf_q;
    word_d[int'(lane_q) * COEF_W +: COEF_W] = coef_d;
  end

  // Loader FSM: packing buffer feeds the output register, which acts as the
  // second buffer so a handshake in a write cycle starts the next word cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      word_idx_q <= '0;
      lane_q     <= '0;
      buf_q      <= '0;
      w_data_q   <= '0;
      w_addr_q   <= '0;
      w_en_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      w_en_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            word_idx_q <= '0;
            lane_q     <= '0;
            buf_q      <= '0;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (keep) begin
            if (lane_q == LANE_W'(COEFS_PER_WORD - 1)) begin
              w_en_q     <= 1'b1;
              w_data_q   <= word_d;
              w_addr_q   <= base_q + {{(8 - WIDX_W){1'b0}}, word_idx_q};
              buf_q      <= '0;
              lane_q     <= '0;
              word_idx_q <= word_idx_q + WIDX_W'(1);
              if (word_idx_q == WIDX_W'(WORDS_PER_POLY - 1)) begin
                state_q <= ST_FINISH;
              end
            end else begin
              buf_q  <= word_d;
              lane_q <= lane_q + LANE_W'(1);
            end
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_loader.sv
// Self-checking bench for poly_loader: table of load runs against a
// queue-based reference model, plus a mid-load reset sequence.
module tb_poly_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [11:0] in_coef;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] w_data;
  logic [7:0]  w_addr;
  logic        w_en;
  logic        busy;
  logic        done;

  poly_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .in_coef   (in_coef),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .w_data    (w_data),
    .w_addr    (w_addr),
    .w_en      (w_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Observed writes and done pulses
  logic [7:0]  wa[$];
  logic [95:0] wd[$];
  int          wc[$];
  int          ndone;
  int          done_cyc;
  logic        busy_at_done;

  // Reference model: list of coefficients that must land in memory, in order
  logic [11:0] kept[$];
  logic [95:0] ref0[32];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (w_en) begin
      wa.push_back(w_addr);
      wd.push_back(w_data);
      wc.push_back(cyc);
    end
    if (done) begin
      ndone        = ndone + 1;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void model_push(input logic [11:0] v);
`ifdef POLY_LOADER_REJECT_EN
    if (v < 12'd3329) kept.push_back(v);
`else
    kept.push_back((v >= 12'd3329) ? v - 12'd3329 : v);
`endif
  endfunction

  function automatic logic [11:0] gen(input int mode, input int n);
    case (mode)
      0:       return 12'(n);
      1:       return (n % 3 == 1) ? 12'd3329 :
                      (n % 5 == 2) ? 12'd4095 : 12'($urandom_range(0, 3328));
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  function automatic logic [95:0] exp_word(input int k);
    logic [95:0] w;
    w = '0;
    for (int j = 0; j < 8; j++) w[12*j +: 12] = kept[8*k + j];
    return w;
  endfunction

  task automatic clear_obs();
    wa.delete(); wd.delete(); wc.delete();
    kept.delete();
    ndone = 0;
    done_cyc = -1;
    busy_at_done = 1'bx;
  endtask

  // Issue start, then feed coefficients until the model holds 256 kept values.
  task automatic run_load(input logic [7:0] base, input int mode, input int gap, input int ss_at);
    int n;
    int guard;
    clear_obs();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = base ^ 8'h55;
    n = 0;
    guard = 0;
    while (kept.size() < 256 && guard < 20000) begin
      in_valid = ($urandom_range(0, 99) >= gap);
      in_coef  = gen(mode, n);
      start    = (n == ss_at);
      if (n == 10) chk("busy_in_load", 96'(busy), 96'd1);
      if (in_valid && in_ready) begin
        model_push(in_coef);
        n++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (guard >= 20000) chk("feed_timeout", 96'(kept.size()), 96'd256);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_run(input logic [7:0] base, input logic [7:0] first, input logic [7:0] last);
    chk("num_writes", 96'(wa.size()), 96'd32);
    for (int k = 0; k < 32; k++) begin
      if (k < wa.size()) begin
        chk($sformatf("addr[%0d]", k), 96'(wa[k]), 96'((base + k) & 255));
        chk($sformatf("data[%0d]", k), wd[k], exp_word(k));
      end
    end
    if (wa.size() == 32) begin
      chk("first_addr", 96'(wa[0]), 96'(first));
      chk("last_addr", 96'(wa[31]), 96'(last));
      chk("done_latency", 96'(done_cyc), 96'(wc[31] + 1));
    end
    chk("done_count", 96'(ndone), 96'd1);
    chk("busy_at_done", 96'(busy_at_done), 96'd0);
    chk("busy_after", 96'(busy), 96'd0);
  endtask

  typedef struct {
    logic [7:0] base;
    int         mode;
    int         gap;
    int         ss_at;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [95:0] w0_exp;
    tbl[0] = '{8'h10, 0, 0,  -1, 8'h10, 8'h2F};
    tbl[1] = '{8'hF0, 0, 0,  -1, 8'hF0, 8'h0F};
    tbl[2] = '{8'h33, 1, 0,  -1, 8'h33, 8'h52};
    tbl[3] = '{8'h80, 2, 30, -1, 8'h80, 8'h9F};
    tbl[4] = '{8'h10, 0, 40, 37, 8'h10, 8'h2F};

    rst = 1'b1; start = 1'b0; base_addr = '0; in_coef = '0; in_valid = 1'b0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 96'(in_ready), 96'd0);
    chk("rst_w_en", 96'(w_en), 96'd0);
    chk("rst_done", 96'(done), 96'd0);
    chk("rst_busy", 96'(busy), 96'd0);
    chk("rst_w_data", w_data, 96'd0);
    chk("rst_w_addr", 96'(w_addr), 96'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_in_ready", 96'(in_ready), 96'd0);

    for (int i = 0; i < 5; i++) begin
      run_load(tbl[i].base, tbl[i].mode, tbl[i].gap, tbl[i].ss_at);
      check_run(tbl[i].base, tbl[i].exp_first, tbl[i].exp_last);
      if (i == 0 && wd.size() == 32) begin
        w0_exp = 96'h007006005004003002001000;
        chk("word0_lanes", wd[0], w0_exp);
        for (int k = 0; k < 32; k++) ref0[k] = wd[k];
      end
      if (i == 2 && wd.size() == 32) begin
`ifdef POLY_LOADER_REJECT_EN
        for (int k = 0; k < 32; k++)
          for (int j = 0; j < 8; j++)
            chk("rej_lane_lt_q", 96'(wd[k][12*j +: 12] < 12'd3329), 96'd1);
`else
        chk("red_3329", 96'(wd[0][23:12]), 96'd0);
        chk("red_4095", 96'(wd[0][35:24]), 96'd766);
`endif
      end
      if (i == 4 && wd.size() == 32) begin
        for (int k = 0; k < 32; k++) chk($sformatf("gapfree_eq[%0d]", k), wd[k], ref0[k]);
      end
    end

    // Reset after 100 coefficients: 12 full words written, partial word dropped
    clear_obs();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h20;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      in_valid = 1'b1;
      in_coef  = 12'(n);
      @(posedge clk); #1;
    end
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 96'(in_ready), 96'd0);
    chk("mid_rst_w_en", 96'(w_en), 96'd0);
    chk("mid_rst_busy", 96'(busy), 96'd0);
    chk("mid_rst_done", 96'(done), 96'd0);
    chk("mid_rst_w_data", w_data, 96'd0);
    chk("mid_rst_w_addr", 96'(w_addr), 96'd0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("abort_writes", 96'(wa.size()), 96'd12);
    chk("abort_done", 96'(ndone), 96'd0);
    if (wa.size() > 0) chk("abort_last_addr", 96'(wa[wa.size() - 1]), 96'h2B);

    run_load(8'h10, 0, 0, -1);
    check_run(8'h10, 8'h10, 8'h2F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
